// File: rtl/factorial_pkg.sv
// Shared types, default widths and a reference factorial for the factorial engine family.
package factorial_pkg;

  localparam int DEF_IN_DATA_WD  = 4;
  localparam int DEF_OUT_DATA_WD = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef struct packed {
    logic [DEF_OUT_DATA_WD-1:0] data;
    logic                       ovf;
  } fact_res_t;

  // Truncated n! plus a sticky flag set whenever a partial product spills past the result width.
  function automatic fact_res_t ref_factorial(input logic [DEF_IN_DATA_WD-1:0] n);
    fact_res_t                    r;
    logic [2*DEF_OUT_DATA_WD-1:0] p;
    r.data = DEF_OUT_DATA_WD'(1);
    r.ovf  = 1'b0;
    for (int i = 2; i <= int'(n); i++) begin
      p      = {{DEF_OUT_DATA_WD{1'b0}}, r.data} * (2*DEF_OUT_DATA_WD)'(i);
      r.ovf  = r.ovf | (|p[2*DEF_OUT_DATA_WD-1:DEF_OUT_DATA_WD]);
      r.data = p[DEF_OUT_DATA_WD-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/factorial_mul_ovf.sv
// Combinational accumulator x multiplier step: truncated product plus high-half overflow bit.
module factorial_mul_ovf #(
  parameter int IN_DATA_WD  = 4,
  parameter int OUT_DATA_WD = 32
) (
  input  logic [OUT_DATA_WD-1:0] a,
  input  logic [IN_DATA_WD:0]    b,
  output logic [OUT_DATA_WD-1:0] prod,
  output logic                   ovf
);

  logic [2*OUT_DATA_WD-1:0] full;

  assign full = {{OUT_DATA_WD{1'b0}}, a} * {{(2*OUT_DATA_WD-IN_DATA_WD-1){1'b0}}, b};
  assign prod = full[OUT_DATA_WD-1:0];
  assign ovf  = |full[2*OUT_DATA_WD-1:OUT_DATA_WD];

endmodule

// File: rtl/factorial_engine.sv
// Iterative n! engine: one multiply per cycle, ready/valid on both sides, sticky overflow.
module factorial_engine
  import factorial_pkg::*;
#(
  parameter int IN_DATA_WD  = DEF_IN_DATA_WD,
  parameter int OUT_DATA_WD = DEF_OUT_DATA_WD
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [IN_DATA_WD-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_DATA_WD-1:0] out_data,
  output logic                   out_overflow,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_busy
);

  state_t                 state_q, state_d;
  logic [IN_DATA_WD-1:0]  n_q;
  // One extra bit so k can reach 2^IN_DATA_WD and terminate the loop for the largest n.
  logic [IN_DATA_WD:0]    k_q;
  logic [OUT_DATA_WD-1:0] acc_q;
  logic                   ovf_q;
  logic [OUT_DATA_WD-1:0] prod;
  logic                   mul_ovf;
  logic                   calc_end;

  factorial_mul_ovf #(
    .IN_DATA_WD (IN_DATA_WD),
    .OUT_DATA_WD(OUT_DATA_WD)
  ) u_mul (
    .a   (acc_q),
    .b   (k_q),
    .prod(prod),
    .ovf (mul_ovf)
  );

  assign calc_end = (k_q > {1'b0, n_q});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_busy  = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        out_busy = 1'b0;
        if (in_valid) state_d = CALC;
      end
      CALC: if (calc_end) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      n_q   <= '0;
      k_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          n_q   <= in_data;
          k_q   <= (IN_DATA_WD+1)'(2);
          acc_q <= OUT_DATA_WD'(1);
          ovf_q <= 1'b0;
        end
        CALC: if (!calc_end) begin
          acc_q <= prod;
          ovf_q <= ovf_q | mul_ovf;
          k_q   <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // acc/ovf are frozen in DONE, so the result is stable under backpressure.
  assign out_data     = acc_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_factorial_engine.sv
// Self-checking bench: directed and random operands against a plain-arithmetic factorial model.
module tb_factorial_engine;

  localparam int IW = 4;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_overflow;
  logic          out_valid;
  logic          out_ready;
  logic          out_busy;

  int checks   = 0;
  int failures = 0;

  factorial_engine #(.IN_DATA_WD(IW), .OUT_DATA_WD(OW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_overflow(out_overflow),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_busy    (out_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // True n! fits in 64 bits for n<=15; truncate and compare against 2^32 afterwards.
  function automatic longint unsigned fact(input int n);
    longint unsigned f = 1;
    for (int i = 2; i <= n; i++) f = f * longint'(i);
    return f;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_busy"}, out_busy, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_ovf"}, out_overflow, 0);
  endtask

  // One full transaction; stall = cycles out_ready stays low after out_valid rises.
  task automatic do_op(input int n, input int stall, input bit poke);
    longint unsigned f;
    int              lat;
    int              exp_lat;
    logic [OW-1:0]   exp_data;
    logic            exp_ovf;
    f        = fact(n);
    exp_data = f[OW-1:0];
    exp_ovf  = (f > 64'hFFFF_FFFF);
    exp_lat  = (n <= 1) ? 1 : n;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = IW'(n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy_after_e0", out_busy, 1);
    chk("in_ready_after_e0", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("latency_n%0d", n), lat, exp_lat);
    if (!out_valid) return;
    chk($sformatf("data_n%0d", n), out_data, exp_data);
    chk($sformatf("ovf_n%0d", n), out_overflow, exp_ovf);
    for (int s = 0; s < stall; s++) begin
      if (poke) begin
        in_valid = s[0];
        in_data  = 4'd3;
      end
      @(posedge clk);
      #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, exp_data);
      chk("stall_ovf", out_overflow, exp_ovf);
      chk("stall_busy", out_busy, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_after_xfer", out_valid, 0);
    chk("in_ready_after_xfer", in_ready, 1);
    chk("busy_after_xfer", out_busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_vals("idle");

    do_op(0, 0, 0);
    do_op(1, 0, 0);
    do_op(5, 0, 0);
    do_op(12, 0, 0);
    do_op(13, 0, 0);
    do_op(15, 0, 0);
    do_op(7, 10, 1);

    // Abort n=9 mid-calculation with an asynchronous reset between edges.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      chk("no_valid_after_abort", out_valid, 0);
    end
    do_op(4, 0, 0);

    for (int i = 0; i < 25; i++) begin
      do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/factorial_engine.md
# factorial_engine

Parametrised iterative factorial unit, next generation of the team's 3-bit/16-bit factorial DUT. It computes n! for an IN_DATA_WD-bit operand into an OUT_DATA_WD-bit result, one multiply per cycle. It adds a ready/valid handshake on both sides, output backpressure, and a sticky overflow flag. It sits behind the factorial agent interface family and is verified with the same bench infrastructure.

## Interface
- IN_DATA_WD, default 4: operand width; n ranges 0..2^IN_DATA_WD-1.
- OUT_DATA_WD, default 32: result width; results are truncated modulo 2^OUT_DATA_WD.
- clk  input  1  single clock; all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- in_data  input  IN_DATA_WD  operand n; sampled only on input handshake.
- in_valid  input  1  operand valid.
- in_ready  output  1  engine can accept an operand.
- out_data  output  OUT_DATA_WD  n! mod 2^OUT_DATA_WD.
- out_overflow  output  1  true n! exceeded 2^OUT_DATA_WD-1; qualified by out_valid.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_busy  output  1  engine holds an operand or an unconsumed result.

## Operation
- FSM states IDLE, CALC, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready: n_q←in_data, acc←1, k←2, ovf←0, go CALC.
- CALC: if k>n_q → DONE, no multiply. Else acc←low OUT_DATA_WD bits of acc*k, ovf←ovf | (upper OUT_DATA_WD bits ≠ 0), k←k+1.
- k is IN_DATA_WD+1 bits wide so that k=2^IN_DATA_WD never wraps. Product is 2*OUT_DATA_WD bits wide before truncation.
- Overflow is sticky. Computation continues after overflow, so latency depends only on n.
- DONE: out_valid=1, out_data=acc, out_overflow=ovf, all held stable until out_valid&&out_ready; then → IDLE.
- out_busy = (state≠IDLE). in_ready = (state==IDLE).
- in_valid while busy is ignored; no queuing, and the operand is not captured.
- n=0 and n=1 both yield 1, overflow 0.
- Reset mid-operation: CALC/DONE abort immediately; no result is emitted.

## Timing
- Reset values: in_ready=1, out_valid=0, out_busy=0, out_data=0, out_overflow=0. Internal acc=0, k=0, n_q=0.
- Let E0 be the clock edge completing the input handshake. out_busy rises after E0; in_ready falls after E0.
- out_valid rises after edge E0+max(n,1): 1 cycle for n≤1, n cycles otherwise.
- Result handshake at edge Ed: out_valid falls and in_ready rises after Ed. The earliest next input handshake is Ed+1; there is no same-cycle turnaround.
- out_ready high before out_valid has no effect; it does not shorten latency.
- out_data and out_overflow are don't-care when out_valid=0, but must not toggle while out_valid=1 and out_ready=0.

## Structure
- factorial_pkg holds:
  - state enum typedef (IDLE, CALC, DONE);
  - default width localparams;
  - a ref_factorial function (result + overflow) shared with the scoreboard.
- One sub-module, factorial_mul_ovf: combinational OUT_DATA_WD×(IN_DATA_WD+1) multiply returning the truncated product and an overflow bit.
- FSM, counters and output registers stay in factorial_engine.
- The existing interface is extended, as a parametrised copy, with in_ready, out_ready and out_overflow.

## Test plan
- Reset, then idle 5 cycles → in_ready=1, out_valid=0, out_busy=0, out_data=0, out_overflow=0. Assert resetn low asynchronously between edges → outputs return to reset values without a clock edge.
- Default widths, n=0, then n=1, out_ready=1 → each gives out_data=1, out_overflow=0, out_valid after E0+1.
- n=5 → out_data=120 after E0+5. n=12 → 479001600, overflow=0, after E0+12.
- n=13 → out_data=1932053504, out_overflow=1. n=15 → out_data=2004310016, out_overflow=1, after E0+15 (checks that k does not wrap).
- n=7 with out_ready held low 10 cycles past out_valid → 5040 held stable, out_busy=1, in_ready=0. in_valid pulses with n=3 during busy are ignored. Releasing out_ready → single transfer, in_ready high next cycle.
- resetn asserted 3 cycles into n=9 → no out_valid; after release, n=4 → 24 at E0+4.
